// File: rtl/morse_letter_receiver.sv
// Morse letter receiver: times key presses/releases in tick units and decodes A..H.
// Optional MORSE_RX_SYNC_EN adds a 2-flop synchronizer on key_i (2 cycles extra latency).
module morse_letter_receiver #(
    parameter int DASH_UNITS = 3,
    parameter int GAP_UNITS  = 3
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       key_i,
    input  logic       tick_i,
    output logic [3:0] code_o,
    output logic [2:0] len_o,
    output logic [2:0] letter_o,
    output logic       valid_o,
    output logic       err_o
);

    typedef enum logic [1:0] {
        IDLE,
        MARK,
        SPACE
    } state_t;

    localparam logic [2:0] DASH_CNT = (DASH_UNITS > 7) ? 3'd7 : 3'(DASH_UNITS);
    localparam logic [2:0] GAP_CNT  = (GAP_UNITS > 7) ? 3'd7 : 3'(GAP_UNITS);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [3:0] acc_q, acc_d;
    logic [2:0] nsym_q, nsym_d;
    logic       ovf_q, ovf_d;
    logic       eval;
    logic       key_s;
    logic       key_prev;
    logic       key_rise;
    logic       key_fall;
    logic [2:0] cnt_inc;
    logic       hit;
    logic [2:0] hit_idx;

`ifdef MORSE_RX_SYNC_EN
    logic key_meta;
    logic key_sync;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            key_meta <= 1'b0;
            key_sync <= 1'b0;
            key_prev <= 1'b0;
        end else begin
            key_meta <= key_i;
            key_sync <= key_meta;
            key_prev <= key_sync;
        end
    end

    assign key_s = key_sync;
`else
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            key_prev <= 1'b0;
        end else begin
            key_prev <= key_i;
        end
    end

    assign key_s = key_i;
`endif

    assign key_rise = key_s & ~key_prev;
    assign key_fall = ~key_s & key_prev;
    assign cnt_inc  = (cnt_q == 3'd7) ? 3'd7 : 3'(cnt_q + 3'd1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            acc_q   <= 4'd0;
            nsym_q  <= 3'd0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            nsym_q  <= nsym_d;
            ovf_q   <= ovf_d;
        end
    end

    // A key edge always clears the counter, so a coincident tick is dropped.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        nsym_d  = nsym_q;
        ovf_d   = ovf_q;
        eval    = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_rise) begin
                    state_d = MARK;
                    cnt_d   = 3'd0;
                    acc_d   = 4'd0;
                    nsym_d  = 3'd0;
                    ovf_d   = 1'b0;
                end
            end
            MARK: begin
                if (key_fall) begin
                    if (nsym_q < 3'd4) begin
                        acc_d[nsym_q[1:0]] = (cnt_q >= DASH_CNT);
                        nsym_d = 3'(nsym_q + 3'd1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                    cnt_d   = 3'd0;
                    state_d = SPACE;
                end else if (tick_i) begin
                    cnt_d = cnt_inc;
                end
            end
            SPACE: begin
                if (key_rise) begin
                    cnt_d   = 3'd0;
                    state_d = MARK;
                end else if (tick_i) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == GAP_CNT) begin
                        state_d = IDLE;
                        eval    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Table lookup on {length, code}; code bit 0 is the first symbol, 1 = dash.
    always_comb begin
        hit     = 1'b1;
        hit_idx = 3'd0;
        case ({nsym_q, acc_q})
            7'b010_0010: hit_idx = 3'd0;
            7'b100_0001: hit_idx = 3'd1;
            7'b100_0101: hit_idx = 3'd2;
            7'b011_0001: hit_idx = 3'd3;
            7'b001_0000: hit_idx = 3'd4;
            7'b100_0100: hit_idx = 3'd5;
            7'b011_0011: hit_idx = 3'd6;
            7'b100_0000: hit_idx = 3'd7;
            default:     hit     = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            code_o   <= 4'd0;
            len_o    <= 3'd0;
            letter_o <= 3'd0;
            valid_o  <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            err_o   <= 1'b0;
            if (eval) begin
                code_o <= acc_q;
                len_o  <= ovf_q ? 3'd4 : nsym_q;
                if (hit && !ovf_q) begin
                    letter_o <= hit_idx;
                    valid_o  <= 1'b1;
                end else begin
                    err_o <= 1'b1;
                end
            end
        end
    end

endmodule
